// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush/bubble control for a 5-stage MIPS pipeline,
// with data-memory wait timeout and saturating stall/flush counters.
module pipeline_sequencer #(
   parameter int MEM_TIMEOUT = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [5:0]  id_op_i,
   input  logic [4:0]  id_rs_i,
   input  logic [4:0]  id_rt_i,
   input  logic        id_br_eq_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rt_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        freeze_o,
   output logic [1:0]  state_o,
   output logic        err_o,
   output logic [15:0] stall_cnt_o,
   output logic [15:0] flush_cnt_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_ERR = 2'd3} state_t;
   state_t      r_state;
   logic [7:0]  r_wait;
   logic        r_err;
   logic [15:0] r_stall;
   logic [15:0] r_flush;
   logic        w_run;
   logic        w_hold;
   logic        w_mem_stall;
   logic        w_lu;
   logic        w_ctrl;
   logic        w_adv;
   logic        w_stall_inc;
   assign w_run       = (r_state == S_RUN);
   assign w_hold      = (r_state == S_WAIT) || (r_state == S_ERR);
   assign w_mem_stall = mem_req_i && !mem_ack_i;
   assign w_lu        = ex_memread_i && (ex_rt_i != 5'd0) &&
                        ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
   assign w_ctrl      = (id_op_i == 6'h02) || ((id_op_i == 6'h04) && id_br_eq_i);
   // freeze outranks load-use, which outranks the control flush
   assign w_adv         = w_run && !w_mem_stall && !w_lu;
   assign pc_write_o    = w_adv;
   assign ifid_write_o  = w_adv;
   assign ifid_flush_o  = w_adv && w_ctrl;
   assign idex_bubble_o = (r_state == S_IDLE) || (w_run && !w_mem_stall && w_lu);
   assign freeze_o      = w_hold || (w_run && w_mem_stall);
   assign state_o       = r_state;
   assign err_o         = r_err;
   assign stall_cnt_o   = r_stall;
   assign flush_cnt_o   = r_flush;
   assign w_stall_inc   = (w_run || (r_state == S_WAIT)) && !pc_write_o;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_wait  <= 8'd0;
         r_err   <= 1'b0;
         r_stall <= 16'd0;
         r_flush <= 16'd0;
      end else begin
         if (w_stall_inc && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
         if (ifid_flush_o && r_flush != 16'hFFFF) r_flush <= r_flush + 16'd1;
         case (r_state)
            S_IDLE: if (start_i) r_state <= S_RUN;
            S_RUN: begin
               // a pending access must complete even if start_i drops
               if (w_mem_stall) begin
                  r_state <= S_WAIT;
                  r_wait  <= 8'd0;
               end else if (!start_i) r_state <= S_IDLE;
            end
            S_WAIT: begin
               if (mem_ack_i) begin
                  r_state <= S_RUN;
                  r_wait  <= 8'd0;
               end else if (r_wait == 8'(MEM_TIMEOUT - 1)) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else r_wait <= r_wait + 8'd1;
            end
            default: r_state <= S_ERR;
         endcase
      end
   end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed stimulus with a queued scoreboard; the
// monitor checks control outputs and counters every cycle an entry is queued.
module tb_pipeline_sequencer;
   logic        clk_i = 1'b0;
   logic        rst_i, start_i, id_br_eq_i, ex_memread_i, mem_req_i, mem_ack_i;
   logic [5:0]  id_op_i;
   logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
   logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o, err_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt_o, flush_cnt_o;

   // {pc_write, ifid_write, flush, bubble, freeze, state[1:0], err}
   localparam logic [7:0] IDLE_E = 8'b0_0_0_1_0_00_0;
   localparam logic [7:0] RUN_E  = 8'b1_1_0_0_0_01_0;
   localparam logic [7:0] LU_E   = 8'b0_0_0_1_0_01_0;
   localparam logic [7:0] FL_E   = 8'b1_1_1_0_0_01_0;
   localparam logic [7:0] FZ_E   = 8'b0_0_0_0_1_01_0;
   localparam logic [7:0] MW_E   = 8'b0_0_0_0_1_10_0;
   localparam logic [7:0] ER_E   = 8'b0_0_0_0_1_11_1;

   typedef struct {
      string       nm;
      logic [7:0]  ctl;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   pipeline_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .id_op_i(id_op_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_br_eq_i(id_br_eq_i),
      .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .mem_req_i(mem_req_i),
      .mem_ack_i(mem_ack_i), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
      .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o),
      .state_o(state_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (q.size() != 0) begin
         exp_t e;
         logic [7:0] act;
         e = q.pop_front();
         act = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o, state_o, err_o};
         checks++;
         if (act !== e.ctl) begin
            errors++;
            $display("FAIL %s ctl: got %b expected %b", e.nm, act, e.ctl);
         end
         checks++;
         if (stall_cnt_o !== e.sc || flush_cnt_o !== e.fc) begin
            errors++;
            $display("FAIL %s counters: got stall=%h flush=%h expected stall=%h flush=%h",
                     e.nm, stall_cnt_o, flush_cnt_o, e.sc, e.fc);
         end
      end
   end

   task automatic cyc(input string nm, input logic [7:0] ctl, input logic [15:0] sc, input logic [15:0] fc);
      exp_t e;
      e.nm = nm; e.ctl = ctl; e.sc = sc; e.fc = fc;
      q.push_back(e);
      @(posedge clk_i); #1;
   endtask

   task automatic quiet();
      id_op_i = 6'h00; id_rs_i = 5'd0; id_rt_i = 5'd0; id_br_eq_i = 1'b0;
      ex_memread_i = 1'b0; ex_rt_i = 5'd0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   task automatic set_lu();
      ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
   endtask

   initial begin
      rst_i = 1'b0; start_i = 1'b0;
      quiet();
      @(posedge clk_i); #1;
      cyc("reset", IDLE_E, 16'd0, 16'd0);
      rst_i = 1'b1;
      for (int i = 0; i < 3; i++) cyc("idle", IDLE_E, 16'd0, 16'd0);
      start_i = 1'b1;
      cyc("start_edge", IDLE_E, 16'd0, 16'd0);
      cyc("run", RUN_E, 16'd0, 16'd0);
      set_lu();
      cyc("load_use", LU_E, 16'd0, 16'd0);
      quiet();
      cyc("after_lu", RUN_E, 16'd1, 16'd0);
      ex_memread_i = 1'b1;
      cyc("lu_rt0", RUN_E, 16'd1, 16'd0);
      quiet(); id_op_i = 6'h04; id_br_eq_i = 1'b1;
      cyc("beq_taken", FL_E, 16'd1, 16'd0);
      id_br_eq_i = 1'b0;
      cyc("beq_not", RUN_E, 16'd1, 16'd1);
      id_op_i = 6'h02;
      cyc("jump", FL_E, 16'd1, 16'd1);
      quiet();
      cyc("flush_cnt2", RUN_E, 16'd1, 16'd2);
      id_op_i = 6'h04; id_br_eq_i = 1'b1; ex_memread_i = 1'b1; ex_rt_i = 5'd9; id_rt_i = 5'd9;
      cyc("beq_lu", LU_E, 16'd1, 16'd2);
      quiet();
      cyc("run2", RUN_E, 16'd2, 16'd2);
      mem_req_i = 1'b1;
      cyc("mem_req", FZ_E, 16'd2, 16'd2);
      cyc("mem_wait1", MW_E, 16'd3, 16'd2);
      cyc("mem_wait2", MW_E, 16'd4, 16'd2);
      mem_ack_i = 1'b1;
      cyc("mem_ack", MW_E, 16'd5, 16'd2);
      quiet();
      cyc("mem_done", RUN_E, 16'd6, 16'd2);
      mem_req_i = 1'b1; mem_ack_i = 1'b1;
      cyc("mem_1cyc", RUN_E, 16'd6, 16'd2);
      quiet(); start_i = 1'b0;
      cyc("stop", RUN_E, 16'd6, 16'd2);
      start_i = 1'b1;
      cyc("stopped", IDLE_E, 16'd6, 16'd2);
      cyc("restart", RUN_E, 16'd6, 16'd2);
      mem_req_i = 1'b1; start_i = 1'b0;
      cyc("to_req", FZ_E, 16'd6, 16'd2);
      cyc("to_w1", MW_E, 16'd7, 16'd2);
      cyc("to_w2", MW_E, 16'd8, 16'd2);
      cyc("to_w3", MW_E, 16'd9, 16'd2);
      cyc("to_w4", MW_E, 16'd10, 16'd2);
      cyc("error", ER_E, 16'd11, 16'd2);
      mem_ack_i = 1'b1; start_i = 1'b1;
      cyc("error_hold1", ER_E, 16'd11, 16'd2);
      cyc("error_hold2", ER_E, 16'd11, 16'd2);
      quiet(); rst_i = 1'b0;
      cyc("err_reset", IDLE_E, 16'd0, 16'd0);
      rst_i = 1'b1;
      cyc("rerun_edge", IDLE_E, 16'd0, 16'd0);
      set_lu();
      for (int i = 0; i < 65540; i++) begin
         @(posedge clk_i); #1;
      end
      cyc("sat_lu", LU_E, 16'hFFFF, 16'd0);
      quiet();
      cyc("sat_run", RUN_E, 16'hFFFF, 16'd0);
      mem_req_i = 1'b1;
      cyc("mid_req", FZ_E, 16'hFFFF, 16'd0);
      cyc("mid_wait", MW_E, 16'hFFFF, 16'd0);
      rst_i = 1'b0;
      cyc("mid_reset", IDLE_E, 16'd0, 16'd0);
      rst_i = 1'b1; quiet();
      for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk_i);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
